// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings, default
// cycle counts and the shared counter width.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST     = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_SYS_HOLD    = 3'd3,
        ST_RUN         = 3'd4
    } seq_state_e;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_SYS_RST_HOLD_CYCLES = 256;
    localparam int DEF_LOSS_FILTER_CYCLES  = 4;
    localparam int DEF_CNT_W               = 20;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous level signals into
// the clk domain; both stages clear to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up / recovery sequencer for the system PLL: pulses the PLL reset,
// qualifies lock, holds off the system reset, and restarts on loss or request.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int SYS_RST_HOLD_CYCLES = DEF_SYS_RST_HOLD_CYCLES,
    parameter int LOSS_FILTER_CYCLES  = DEF_LOSS_FILTER_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] LD_PLL_RST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STABLE    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(SYS_RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       retry_q;
    logic [3:0]       retry_d;
    logic [7:0]       loss_q;
    logic [7:0]       loss_d;
    logic             pll_rst_q;
    logic             pll_rst_d;
    logic             sys_rst_n_q;
    logic             sys_rst_n_d;
    logic             ready_q;
    logic             ready_d;
    logic             lk_s;
    logic             cnt_zero;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (soft_rst_req) begin
            // A soft request overrides everything, including a same-cycle loss detection.
            state_d = ST_PLL_RST;
            cnt_d   = LD_PLL_RST;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_zero) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LD_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = ST_LOCK_STABLE;
                        cnt_d   = LD_STABLE;
                    end else if (cnt_zero) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = LD_PLL_RST;
                        if (retry_q != 4'hF) begin
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_LOCK_STABLE: begin
                    if (!lk_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LD_TIMEOUT;
                    end else if (cnt_zero) begin
                        state_d = ST_SYS_HOLD;
                        cnt_d   = LD_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_SYS_HOLD: begin
                    if (!lk_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = LD_TIMEOUT;
                    end else if (cnt_zero) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // In RUN the counter counts up consecutive low-lock cycles.
                    if (lk_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOSS_LAST) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = LD_PLL_RST;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = LD_PLL_RST;
                end
            endcase
        end

        pll_rst_d   = (state_d == ST_PLL_RST);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= LD_PLL_RST;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer with shortened cycle parameters;
// expectations come from the sequencing rules expressed as cycle arithmetic.
module tb_pll_reset_sequencer;

    localparam int PLL_RST_CYCLES      = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 50;
    localparam int SYS_RST_HOLD_CYCLES = 6;
    localparam int LOSS_FILTER_CYCLES  = 3;
    localparam int SYNC_LAT            = 2;

    logic       refclk       = 1'b0;
    logic       rst_n        = 1'b0;
    logic       pll_locked   = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_loss = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .SYS_RST_HOLD_CYCLES (SYS_RST_HOLD_CYCLES),
        .LOSS_FILTER_CYCLES  (LOSS_FILTER_CYCLES),
        .CNT_W               (20)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt),
        .state_dbg    (state_dbg)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset(input logic lock);
        pll_locked   = lock;
        soft_rst_req = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n        = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b1; soft_rst_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({pll_rst, sys_rst_n, ready, state_dbg} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got pll_rst/sys_rst_n/ready/state=%b/%b/%b/%0d want 1/0/0/0",
                     pll_rst, sys_rst_n, ready, state_dbg);
        end
        n_checks++;
        if ({retry_cnt, loss_cnt} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got retry=%0d loss=%0d want 0/0", retry_cnt, loss_cnt);
        end
        $display("[tx] reset held: pll_rst=%b sys_rst_n=%b", pll_rst, sys_rst_n);
    endtask

    task automatic test_power_up();
        int n;
        rst_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        n_checks++;
        if (n != PLL_RST_CYCLES) begin
            n_fail++;
            $display("FAIL powerup_pll_rst_width: got %0d cycles want %0d", n, PLL_RST_CYCLES);
        end
        // Lock is already synchronised when pll_rst drops: one WAIT_LOCK cycle, then stable window and hold.
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++;
        if (n != 1 + LOCK_STABLE_CYCLES + SYS_RST_HOLD_CYCLES) begin
            n_fail++;
            $display("FAIL powerup_sys_rst_delay: got %0d cycles want %0d", n,
                     1 + LOCK_STABLE_CYCLES + SYS_RST_HOLD_CYCLES);
        end
        n_checks++;
        if ({ready, pll_rst, retry_cnt, loss_cnt, state_dbg} !== {1'b1, 1'b0, 4'd0, 8'd0, 3'd4}) begin
            n_fail++;
            $display("FAIL powerup_run: got ready=%b pll_rst=%b retry=%0d loss=%0d state=%0d want 1/0/0/0/4",
                     ready, pll_rst, retry_cnt, loss_cnt, state_dbg);
        end
        $display("[tx] power-up: sys_rst_n released after %0d cycles", n);
    endtask

    task automatic test_lock_timeout();
        int n;
        int exp_retry;
        do_reset(1'b0);
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        for (int k = 1; k <= 16; k++) begin
            n = 0;
            while (pll_rst !== 1'b1 && n < 200) begin tick(); n++; end
            n_checks++;
            if (n != LOCK_TIMEOUT_CYCLES) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: got %0d cycles want %0d", k, n, LOCK_TIMEOUT_CYCLES);
            end
            exp_retry = (k > 15) ? 15 : k;
            n_checks++;
            if (retry_cnt !== 4'(exp_retry)) begin
                n_fail++;
                $display("FAIL timeout_retry_cnt[%0d]: got %0d want %0d", k, retry_cnt, exp_retry);
            end
            n = 0;
            while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
            n_checks++;
            if (n != PLL_RST_CYCLES) begin
                n_fail++;
                $display("FAIL timeout_pll_rst_width[%0d]: got %0d want %0d", k, n, PLL_RST_CYCLES);
            end
            $display("[tx] timeout %0d: retry_cnt=%0d", k, retry_cnt);
        end
        n_checks++;
        if ({sys_rst_n, ready, loss_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL timeout_no_run: got sys_rst_n=%b ready=%b loss=%0d want 0/0/0",
                     sys_rst_n, ready, loss_cnt);
        end
    endtask

    task automatic test_lock_glitch();
        int n;
        int r;
        for (int t = 0; t < 3; t++) begin
            do_reset(1'b1);
            n = 0;
            while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
            r = int'($urandom_range(0, 5));
            repeat (r) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            // After the glitch the whole qualification restarts once the restored lock is synchronised.
            n = 0;
            while (sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
            n_checks++;
            if (n != SYNC_LAT + 1 + LOCK_STABLE_CYCLES + SYS_RST_HOLD_CYCLES) begin
                n_fail++;
                $display("FAIL glitch_requalify[%0d]: got %0d cycles want %0d (offset %0d)", t, n,
                         SYNC_LAT + 1 + LOCK_STABLE_CYCLES + SYS_RST_HOLD_CYCLES, r);
            end
            $display("[tx] glitch at offset %0d: sys_rst_n released %0d cycles after lock restored", r, n);
        end
    endtask

    task automatic test_loss_filter();
        int n;
        int d;
        int drop_at;
        int exp_drop;
        logic pll_at_drop;
        do_reset(1'b1);
        exp_loss = 0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin tick(); n++; end
        for (int t = 0; t < 8; t++) begin
            if (t == 0)      d = LOSS_FILTER_CYCLES - 1;
            else if (t == 1) d = LOSS_FILTER_CYCLES;
            else             d = int'($urandom_range(1, LOSS_FILTER_CYCLES + 3));
            pll_locked  = 1'b0;
            drop_at     = 0;
            pll_at_drop = 1'b0;
            for (int c = 1; c <= d + 6; c++) begin
                tick();
                if (ready !== 1'b1 && drop_at == 0) begin
                    drop_at     = c;
                    pll_at_drop = pll_rst;
                end
                if (c == d) pll_locked = 1'b1;
            end
            if (d >= LOSS_FILTER_CYCLES) begin
                exp_drop = SYNC_LAT + LOSS_FILTER_CYCLES;
                if (exp_loss < 255) exp_loss++;
            end else begin
                exp_drop = 0;
            end
            n_checks++;
            if (drop_at != exp_drop) begin
                n_fail++;
                $display("FAIL loss_drop_time[%0d]: low for %0d, ready fell at %0d want %0d (0=never)",
                         t, d, drop_at, exp_drop);
            end
            if (exp_drop != 0) begin
                n_checks++;
                if (pll_at_drop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL loss_pll_rst[%0d]: got %b want 1", t, pll_at_drop);
                end
            end
            n_checks++;
            if (loss_cnt !== 8'(exp_loss)) begin
                n_fail++;
                $display("FAIL loss_cnt[%0d]: got %0d want %0d", t, loss_cnt, exp_loss);
            end
            n = 0;
            while (ready !== 1'b1 && n < 200) begin tick(); n++; end
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL loss_recover[%0d]: ready=%b after %0d cycles want 1", t, ready, n);
            end
            $display("[tx] lock low %0d cycles: loss_cnt=%0d", d, loss_cnt);
        end
    endtask

    task automatic test_soft_reset();
        int n;
        pll_locked = 1'b0;
        repeat (SYNC_LAT + LOSS_FILTER_CYCLES - 1) tick();
        // Pulse lands on the same edge that would register the lock loss.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_checks++;
        if ({pll_rst, ready, sys_rst_n, loss_cnt} !== {1'b1, 1'b0, 1'b0, 8'(exp_loss)}) begin
            n_fail++;
            $display("FAIL soft_coincide: got pll_rst=%b ready=%b sys_rst_n=%b loss=%0d want 1/0/0/%0d",
                     pll_rst, ready, sys_rst_n, loss_cnt, exp_loss);
        end
        pll_locked = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        n_checks++;
        if (n != PLL_RST_CYCLES) begin
            n_fail++;
            $display("FAIL soft_full_reload: got %0d cycles want %0d", n, PLL_RST_CYCLES);
        end
        n = 0;
        while (ready !== 1'b1 && n < 200) begin tick(); n++; end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_checks++;
        if ({pll_rst, ready, retry_cnt, loss_cnt} !== {1'b1, 1'b0, 4'd0, 8'(exp_loss)}) begin
            n_fail++;
            $display("FAIL soft_in_run: got pll_rst=%b ready=%b retry=%0d loss=%0d want 1/0/0/%0d",
                     pll_rst, ready, retry_cnt, loss_cnt, exp_loss);
        end
        $display("[tx] soft reset: loss_cnt held at %0d", loss_cnt);
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (state_dbg !== 3'd3 && n < 300) begin tick(); n++; end
        n_checks++;
        if (state_dbg !== 3'd3) begin
            n_fail++;
            $display("FAIL async_reach_hold: state=%0d after %0d cycles want 3", state_dbg, n);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pll_rst, sys_rst_n, ready, retry_cnt, loss_cnt, state_dbg} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got pll_rst=%b sys_rst_n=%b ready=%b retry=%0d loss=%0d state=%0d want 1/0/0/0/0/0",
                     pll_rst, sys_rst_n, ready, retry_cnt, loss_cnt, state_dbg);
        end
        $display("[tx] async reset mid-hold: state=%0d", state_dbg);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_timeout();
        test_lock_glitch();
        test_loss_filter();
        test_soft_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
